pixel_mixer_pipe: RTL and testbench
===================================

Name: pixel_mixer_pipe

Overview:
- Pipelined, parametrised compositor that merges LAYERS input pixels into one output pixel per beat.
- Merge modes are selected per layer: skip, saturating add, colour-keyed overwrite, or saturating subtract.
- Sits between the sprite/background frame readers and the VGA output stage.
- Replaces the fixed two-input RGB444 saturating adder with a streaming block that uses valid/ready flow control.

Parameters:
- CH_W, 4, bits per colour channel.
- NUM_CH, 3, channels per pixel; channel 0 occupies the pixel LSBs.
- LAYERS, 3, number of input layers (minimum 2); layer 0 is the base.
- KEY, 0 (width NUM_CH*CH_W), transparent colour for overwrite mode.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_sof  in  1  beat is the first pixel of a frame.
- in_pix  in  LAYERS*NUM_CH*CH_W  layer pixels; layer 0 in the LSBs.
- in_mode  in  2*LAYERS  per-layer mode; field k is bits [2k+1:2k]; field 0 is ignored.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_sof  out  1  in_sof delayed with its pixel.
- out_pix  out  NUM_CH*CH_W  merged pixel.

Behaviour:
- Clock and reset: single clock domain `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - out_valid=0, out_sof=0, out_pix=0.
  - All stage valids=0.
  - Mode config register = 01 for every layer (saturating add).
  - in_ready is combinational; it reads 1 once reset releases.
- Handshake:
  - advance = ~out_valid | out_ready; in_ready = advance.
  - A beat is accepted when in_valid & in_ready.
  - The output beat transfers when out_valid & out_ready.
  - The whole pipe shifts only on advance. Bubbles are carried and not collapsed.
  - When stalled, out_pix, out_sof and out_valid hold stable.
- Latency and throughput:
  - Exactly LAYERS cycles from accept to out_valid, when unstalled.
  - One beat per cycle sustained.
- Pipeline structure:
  - Stage 0 registers layer 0 as the accumulator.
  - Stage k (1..LAYERS-1) registers f(acc, layer k, mode k).
  - Unconsumed layer pixels, sof and the effective mode vector travel down delay registers alongside the accumulator.
- Modes are applied per channel, with a and b unsigned CH_W bits:
  - 00: skip; result = acc.
  - 01: saturating add; result = min(a+b, 2^CH_W-1). The sum is computed at CH_W+1 bits.
  - 10: overwrite; result = layer pixel unless the whole layer pixel equals KEY, then acc. The compare is on the full pixel, not per channel.
  - 11: saturating subtract; result = max(a-b, 0).
- Config latch:
  - in_mode is sampled into the config register only on an accepted beat with in_sof=1.
  - That beat itself uses the new in_mode.
  - All other beats use the latched register.
  - in_mode changes mid-frame have no effect until the next sof beat.
- Boundary conditions:
  - in_sof while in_valid=0 is ignored.
  - Simultaneous accept of input and transfer of output is legal every cycle.
  - An out_ready toggle with out_valid=0 has no effect.
  - Reset mid-operation discards all in-flight beats and clears config to all-add.
  - Beats presented in the first post-reset cycle are accepted normally.

Optional Feature:
- Macro: PIXEL_MIXER_SAT_CNT_EN.
- Defined:
  - Adds output port sat_count (out, 16 bits).
  - Counts transferred output beats in which any channel clipped, in any stage, under mode 01 or 11. A per-beat sticky flag travels with the pixel.
  - Resets to 0 on rst_n.
  - Loads 0 or 1 on a transferred beat with out_sof=1, so the count is per frame.
  - Saturates at 16'hFFFF.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan (defaults: LAYERS=3, CH_W=4, NUM_CH=3):
1. Add plus transparent layer:
   - Stimulus: layers {0x000, 0xF0E, 0x123} (layer2..layer0), modes {10,01,xx}, sof=1, out_ready=1.
   - Response: out_pix=12'hF2F, out_sof=1, exactly 3 cycles after accept.
2. Overwrite:
   - Stimulus: same as 1 but layer2=0x456.
   - Response: out_pix=12'h456. Then layer2=KEY gives 12'hF2F again.
3. Subtract clamps:
   - Stimulus: layer0=0x555, layer1=0x16A mode 11, layer2 mode 00.
   - Response: out_pix=12'h400.
4. Backpressure:
   - Stimulus: stream 10 beats with distinct layer0 values, all other modes 00; hold out_ready=0 for 5 cycles with the pipe full.
   - Response: in_ready=0 during the stall, out_pix stable, all 10 values emerge in order with no loss or duplication.
5. Config latch:
   - Stimulus: frame starts in mode 01; switch in_mode to 11 on a non-sof beat.
   - Response: results stay add until the next sof beat, which itself uses subtract.
6. Reset mid-stream:
   - Stimulus: pull rst_n low while out_valid=1.
   - Response: out_valid drops without waiting for clk; after release, config is all-add, and with the macro defined sat_count=0.

Source files
------------

// File: rtl/pixel_mixer_pipe.sv
// pixel_mixer_pipe: streaming LAYERS-input pixel compositor with per-layer merge modes and valid/ready flow control
// Optional: define PIXEL_MIXER_SAT_CNT_EN to add the per-frame clipped-beat counter port sat_count.
module pixel_mixer_pipe #(
    parameter int CH_W = 4,
    parameter int NUM_CH = 3,
    parameter int LAYERS = 3,
    parameter logic [NUM_CH*CH_W-1:0] KEY = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sof,
    input  logic [LAYERS*NUM_CH*CH_W-1:0] in_pix,
    input  logic [2*LAYERS-1:0]           in_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sof,
    output logic [NUM_CH*CH_W-1:0]        out_pix
`ifdef PIXEL_MIXER_SAT_CNT_EN
    ,
    output logic [15:0]                   sat_count
`endif
);
    localparam int PW = NUM_CH*CH_W;
    localparam int MW = 2*LAYERS;

    logic              adv;
    logic [MW-1:0]     cfg;
    logic [MW-1:0]     eff;
    logic [LAYERS-1:0] v_q;
    logic [LAYERS-1:0] sof_q;
    logic [LAYERS-1:0] sat_q;
    logic [LAYERS-1:0] sat_d;
    logic [PW-1:0]     acc_q [LAYERS];
    logic [PW-1:0]     acc_d [LAYERS];
    logic [LAYERS*PW-1:0] pix_q [LAYERS-1];
    logic [MW-1:0]     mode_q [LAYERS-1];

    // One merge step across all channels; MSB of the result flags a clip in add/subtract.
    function automatic logic [PW:0] merge(input logic [PW-1:0] a, input logic [PW-1:0] b, input logic [1:0] m);
        logic [PW-1:0] r;
        logic          c;
        logic [CH_W:0] s;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            s = m[1] ? {1'b0, a[i*CH_W +: CH_W]} - {1'b0, b[i*CH_W +: CH_W]}
                     : {1'b0, a[i*CH_W +: CH_W]} + {1'b0, b[i*CH_W +: CH_W]};
            r[i*CH_W +: CH_W] = s[CH_W] ? (m[1] ? {CH_W{1'b0}} : {CH_W{1'b1}}) : s[CH_W-1:0];
            c = c | s[CH_W];
        end
        return m == 2'b00 ? {1'b0, a} :
               m == 2'b10 ? {1'b0, (b == KEY ? a : b)} : {c, r};
    endfunction

    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign eff       = in_sof ? in_mode : cfg;
    assign out_valid = v_q[LAYERS-1];
    assign out_sof   = sof_q[LAYERS-1];
    assign out_pix   = acc_q[LAYERS-1];

    // Next value of every stage: stage 0 takes the base layer, stage k folds in layer k.
    always_comb begin
        acc_d[0] = in_pix[PW-1:0];
        sat_d    = '0;
        for (int k = 1; k < LAYERS; k++)
            {sat_d[k], acc_d[k]} = merge(acc_q[k-1], pix_q[k-1][k*PW +: PW], mode_q[k-1][2*k +: 2]);
    end

    // Mode config is captured only by an accepted start-of-frame beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cfg <= {LAYERS{2'b01}};
        else if (in_valid & adv & in_sof)
            cfg <= in_mode;
    end

    // Whole pipe shifts together on advance; bubbles travel as invalid slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            sof_q <= '0;
            sat_q <= '0;
            for (int k = 0; k < LAYERS; k++)
                acc_q[k] <= '0;
            for (int k = 0; k < LAYERS-1; k++) begin
                pix_q[k]  <= '0;
                mode_q[k] <= '0;
            end
        end else if (adv) begin
            v_q   <= {v_q[LAYERS-2:0], in_valid};
            sof_q <= {sof_q[LAYERS-2:0], in_sof};
            sat_q <= {sat_q[LAYERS-2:0], 1'b0} | sat_d;
            for (int k = 0; k < LAYERS; k++)
                acc_q[k] <= acc_d[k];
            pix_q[0]  <= in_pix;
            mode_q[0] <= eff;
            for (int k = 1; k < LAYERS-1; k++) begin
                pix_q[k]  <= pix_q[k-1];
                mode_q[k] <= mode_q[k-1];
            end
        end
    end

`ifdef PIXEL_MIXER_SAT_CNT_EN
    // Per-frame count of delivered beats that clipped anywhere, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_count <= '0;
        else if (out_valid & out_ready)
            sat_count <= out_sof ? {15'd0, sat_q[LAYERS-1]} :
                         (sat_q[LAYERS-1] & ~&sat_count) ? sat_count + 16'd1 : sat_count;
    end
`endif
endmodule

// File: tb/tb_pixel_mixer_pipe.sv
// tb_pixel_mixer_pipe: scoreboard bench for the pixel compositor pipeline
module tb_pixel_mixer_pipe;
    localparam int PW = 12;
    localparam int LW = 36;
    localparam int MW = 6;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          in_valid = 0;
    logic          in_sof = 0;
    logic          out_ready = 1;
    logic [LW-1:0] in_pix = '0;
    logic [MW-1:0] in_mode = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_sof;
    logic [PW-1:0] out_pix;
`ifdef PIXEL_MIXER_SAT_CNT_EN
    logic [15:0]   sat_count;
`endif

    always #5 clk = ~clk;

    pixel_mixer_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_pix(in_pix), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sof(out_sof), .out_pix(out_pix)
`ifdef PIXEL_MIXER_SAT_CNT_EN
        , .sat_count(sat_count)
`endif
    );

    typedef struct {
        logic [PW-1:0] pix;
        logic          sof;
        int            cyc;
        bit            lat;
    } exp_t;

    exp_t          q[$];
    exp_t          mon_e;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    logic [PW-1:0] exp_pix = '0;
    bit            exp_lat = 0;
    logic [PW-1:0] hold;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard push: every accepted beat enqueues its hand-computed result.
    always @(negedge clk)
        if (rst_n && in_valid && in_ready)
            q.push_back('{exp_pix, in_sof, cyc, exp_lat});

    // Monitor: every transferred output beat is compared against the queue head.
    always @(negedge clk)
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0)
                check("unexpected_beat", 1, 0);
            else begin
                mon_e = q.pop_front();
                check("out_pix", out_pix, mon_e.pix);
                check("out_sof", out_sof, mon_e.sof);
                if (mon_e.lat)
                    check("latency", cyc - mon_e.cyc, 3);
            end
        end

    task automatic send(input logic [PW-1:0] l2, input logic [PW-1:0] l1, input logic [PW-1:0] l0,
                        input logic [MW-1:0] m, input logic sof, input logic [PW-1:0] e, input bit lat = 0);
        bit ok;
        in_valid = 1;
        in_pix   = {l2, l1, l0};
        in_mode  = m;
        in_sof   = sof;
        exp_pix  = e;
        exp_lat  = lat;
        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok)
            check("accept_timeout", 0, 1);
        in_valid = 0;
        in_sof   = 0;
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && q.size() != 0; t++)
            @(negedge clk);
        if (q.size() != 0)
            check("drain_timeout", q.size(), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL global_timeout");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pix", out_pix, 0);
        check("rst_out_sof", out_sof, 0);
        rst_n = 1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
`ifdef PIXEL_MIXER_SAT_CNT_EN
        check("rst_sat_count", sat_count, 0);
`endif
        // add then transparent overwrite
        send(12'h000, 12'hF0E, 12'h123, 6'b100100, 1, 12'hF2F, 1);
        drain();
`ifdef PIXEL_MIXER_SAT_CNT_EN
        check("sat_count_t1", sat_count, 1);
`endif
        // opaque overwrite, then key pixel again
        send(12'h456, 12'hF0E, 12'h123, 6'b100100, 0, 12'h456);
        send(12'h000, 12'hF0E, 12'h123, 6'b100100, 0, 12'hF2F);
        drain();
`ifdef PIXEL_MIXER_SAT_CNT_EN
        check("sat_count_t2", sat_count, 3);
`endif
        // subtract clamps at zero
        send(12'hABC, 12'h16A, 12'h555, 6'b001100, 1, 12'h400);
        drain();
        // backpressure with the pipe full
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(12'h777, 12'h777, 12'(12'h100 + i), 6'b000000, i == 0, 12'(12'h100 + i));
            end
            begin
                out_ready = 0;
                for (int t = 0; t < 50 && !out_valid; t++)
                    @(negedge clk);
                check("stall_valid", out_valid, 1);
                hold = out_pix;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_hold", out_pix, hold);
                end
                @(posedge clk);
                #1;
                out_ready = 1;
            end
        join
        drain();
        // config latch: mid-frame mode change ignored until next sof
        send(12'h333, 12'h222, 12'h111, 6'b010101, 1, 12'h666);
        send(12'h111, 12'h111, 12'h888, 6'b111100, 0, 12'hAAA);
        send(12'h111, 12'h111, 12'h888, 6'b111100, 1, 12'h666);
        in_sof  = 1;
        in_mode = 6'b000000;
        @(posedge clk);
        #1;
        in_sof  = 0;
        send(12'h111, 12'h222, 12'h888, 6'b000000, 0, 12'h555);
        drain();
        // asynchronous reset mid-stream
        out_ready = 0;
        send(12'h000, 12'h000, 12'h321, 6'b000000, 1, 12'h321);
        send(12'h000, 12'h000, 12'h654, 6'b000000, 0, 12'h654);
        for (int t = 0; t < 50 && !out_valid; t++)
            @(negedge clk);
        check("pre_reset_valid", out_valid, 1);
        #2;
        rst_n = 0;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_pix", out_pix, 0);
        q.delete();
        out_ready = 1;
        @(posedge clk);
        #1;
        rst_n = 1;
        check("post_reset_in_ready", in_ready, 1);
`ifdef PIXEL_MIXER_SAT_CNT_EN
        check("post_reset_sat_count", sat_count, 0);
`endif
        send(12'h789, 12'h456, 12'h123, 6'b000000, 0, 12'hCFF);
        drain();
`ifdef PIXEL_MIXER_SAT_CNT_EN
        check("sat_count_t6", sat_count, 1);
`endif
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
